// File: rtl/id_stage_fwd.sv
// Registered decode stage: operand forwarding, load-use interlock, branch/jump resolution, delay slots.
// Optional build macro COND_MOVE_EN enables MOVN/MOVZ decode.
package id_stage_fwd_pkg;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_AND  = 5'd1,
    ALU_OR   = 5'd2,
    ALU_XOR  = 5'd3,
    ALU_NOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_MFHI = 5'd8,
    ALU_MFLO = 5'd9,
    ALU_MTHI = 5'd10,
    ALU_MTLO = 5'd11,
    ALU_ADDU = 5'd12,
    ALU_LUI  = 5'd13,
    ALU_LW   = 5'd14,
    ALU_BEQ  = 5'd15,
    ALU_BNE  = 5'd16,
    ALU_BGTZ = 5'd17,
    ALU_BLEZ = 5'd18,
    ALU_J    = 5'd19,
    ALU_JAL  = 5'd20,
    ALU_JR   = 5'd21,
    ALU_JALR = 5'd22,
    ALU_MOVN = 5'd23,
    ALU_MOVZ = 5'd24
  } alu_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_MOVN = 6'h0B;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

endpackage

// state  | meaning
// RUN    | accepting instructions unless a hazard or full output blocks
// STALL  | source-0 load-use interlock, counting down before resuming
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [ADDR_W-1:0]     in_addr,
  output logic [4:0]            rf_raddr1,
  output logic [4:0]            rf_raddr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [5*NUM_FWD-1:0]      fwd_addr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic                  out_valid,
  input  logic                  out_ready,
  output alu_t                  out_alu,
  output logic [DATA_W-1:0]     out_oprd1,
  output logic [DATA_W-1:0]     out_oprd2,
  output logic                  out_wen,
  output logic [4:0]            out_waddr,
  output logic [ADDR_W-1:0]     out_link_addr,
  output logic                  out_in_delayslot,
  output logic                  jump_en,
  output logic [ADDR_W-1:0]     jump_target
);

  localparam int CNT_W = 3;

  typedef enum logic {S_RUN, S_STALL} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               ds_flag;

  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd, sa;
  logic [15:0]        imm;
  logic [25:0]        idx;

  assign op    = in_inst[31:26];
  assign rs    = in_inst[25:21];
  assign rt    = in_inst[20:16];
  assign rd    = in_inst[15:11];
  assign sa    = in_inst[10:6];
  assign funct = in_inst[5:0];
  assign imm   = in_inst[15:0];
  assign idx   = in_inst[25:0];

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Returns {is_load, from_src0, data}; lowest matching source index wins.
  function automatic logic [DATA_W+1:0] resolve(
    input logic [4:0]                  a,
    input logic [DATA_W-1:0]           rf_val,
    input logic [NUM_FWD-1:0]          en,
    input logic [5*NUM_FWD-1:0]        addr,
    input logic [DATA_W*NUM_FWD-1:0]   data,
    input logic [NUM_FWD-1:0]          is_load
  );
    logic [DATA_W-1:0] v;
    logic              ld, s0;
    v  = rf_val;
    ld = 1'b0;
    s0 = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (en[i] && addr[5*i +: 5] == a) begin
        v  = data[DATA_W*i +: DATA_W];
        ld = is_load[i];
        s0 = (i == 0);
      end
    end
    if (a == 5'd0) begin
      v  = '0;
      ld = 1'b0;
      s0 = 1'b0;
    end
    return {ld, s0, v};
  endfunction

  logic [DATA_W-1:0]  val1, val2;
  logic               ld1, ld2, src0_1, src0_2;

  always_comb begin
    {ld1, src0_1, val1} = resolve(rs, rf_rdata1, fwd_en, fwd_addr, fwd_data, fwd_is_load);
    {ld2, src0_2, val2} = resolve(rt, rf_rdata2, fwd_en, fwd_addr, fwd_data, fwd_is_load);
  end

  logic [DATA_W-1:0]  imm_sext, imm_zext, imm_lui, sa_zext;
  logic [ADDR_W-1:0]  pc4, pc8, br_target, j_target;

  assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext  = {{(DATA_W-16){1'b0}}, imm};
  assign imm_lui   = {imm, {(DATA_W-16){1'b0}}};
  assign sa_zext   = {{(DATA_W-5){1'b0}}, sa};
  assign pc4       = in_addr + ADDR_W'(4);
  assign pc8       = in_addr + ADDR_W'(8);
  assign br_target = pc4 + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  assign j_target  = {pc4[ADDR_W-1:28], idx, 2'b00};

  alu_t               d_alu;
  logic               use1, use2, d_wen, is_br, taken;
  logic [4:0]         d_waddr;
  logic [DATA_W-1:0]  sub1, sub2;
  logic [ADDR_W-1:0]  d_target, d_link;

  always_comb begin
    d_alu    = ALU_NOP;
    use1     = 1'b0;
    use2     = 1'b0;
    d_wen    = 1'b0;
    d_waddr  = 5'd0;
    sub1     = '0;
    sub2     = '0;
    is_br    = 1'b0;
    taken    = 1'b0;
    d_target = '0;
    d_link   = '0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_AND:  begin d_alu = ALU_AND; use1 = 1'b1; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_OR:   begin d_alu = ALU_OR;  use1 = 1'b1; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_XOR:  begin d_alu = ALU_XOR; use1 = 1'b1; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_NOR:  begin d_alu = ALU_NOR; use1 = 1'b1; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_SLL:  begin d_alu = ALU_SLL; sub1 = sa_zext; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_SRL:  begin d_alu = ALU_SRL; sub1 = sa_zext; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_SRA:  begin d_alu = ALU_SRA; sub1 = sa_zext; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_SLLV: begin d_alu = ALU_SLL; use1 = 1'b1; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_SRLV: begin d_alu = ALU_SRL; use1 = 1'b1; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_SRAV: begin d_alu = ALU_SRA; use1 = 1'b1; use2 = 1'b1; d_wen = 1'b1; d_waddr = rd; end
          FN_MFHI: begin d_alu = ALU_MFHI; d_wen = 1'b1; d_waddr = rd; end
          FN_MFLO: begin d_alu = ALU_MFLO; d_wen = 1'b1; d_waddr = rd; end
          FN_MTHI: begin d_alu = ALU_MTHI; use1 = 1'b1; end
          FN_MTLO: begin d_alu = ALU_MTLO; use1 = 1'b1; end
          FN_JR: begin
            d_alu    = ALU_JR;
            use1     = 1'b1;
            is_br    = 1'b1;
            taken    = 1'b1;
            d_target = ADDR_W'(val1);
          end
          FN_JALR: begin
            d_alu    = ALU_JALR;
            use1     = 1'b1;
            is_br    = 1'b1;
            taken    = 1'b1;
            d_target = ADDR_W'(val1);
            d_wen    = 1'b1;
            d_waddr  = rd;
            d_link   = pc8;
          end
`ifdef COND_MOVE_EN
          // Condition uses the resolved (possibly forwarded) rt value.
          FN_MOVN: begin d_alu = ALU_MOVN; use1 = 1'b1; use2 = 1'b1; d_waddr = rd; d_wen = (val2 != '0); end
          FN_MOVZ: begin d_alu = ALU_MOVZ; use1 = 1'b1; use2 = 1'b1; d_waddr = rd; d_wen = (val2 == '0); end
`else
          FN_MOVN, FN_MOVZ: d_alu = ALU_NOP;
`endif
          default: d_alu = ALU_NOP;
        endcase
      end
      OP_ANDI:  begin d_alu = ALU_AND;  use1 = 1'b1; sub2 = imm_zext; d_wen = 1'b1; d_waddr = rt; end
      OP_ORI:   begin d_alu = ALU_OR;   use1 = 1'b1; sub2 = imm_zext; d_wen = 1'b1; d_waddr = rt; end
      OP_XORI:  begin d_alu = ALU_XOR;  use1 = 1'b1; sub2 = imm_zext; d_wen = 1'b1; d_waddr = rt; end
      OP_ADDIU: begin d_alu = ALU_ADDU; use1 = 1'b1; sub2 = imm_sext; d_wen = 1'b1; d_waddr = rt; end
      OP_LUI:   begin d_alu = ALU_LUI;  sub2 = imm_lui; d_wen = 1'b1; d_waddr = rt; end
      OP_LW:    begin d_alu = ALU_LW;   use1 = 1'b1; sub2 = imm_sext; d_wen = 1'b1; d_waddr = rt; end
      OP_BEQ: begin
        d_alu = ALU_BEQ; use1 = 1'b1; use2 = 1'b1; is_br = 1'b1;
        taken = (val1 == val2); d_target = br_target;
      end
      OP_BNE: begin
        d_alu = ALU_BNE; use1 = 1'b1; use2 = 1'b1; is_br = 1'b1;
        taken = (val1 != val2); d_target = br_target;
      end
      OP_BGTZ: begin
        d_alu = ALU_BGTZ; use1 = 1'b1; is_br = 1'b1;
        taken = !val1[DATA_W-1] && (val1 != '0); d_target = br_target;
      end
      OP_BLEZ: begin
        d_alu = ALU_BLEZ; use1 = 1'b1; is_br = 1'b1;
        taken = val1[DATA_W-1] || (val1 == '0); d_target = br_target;
      end
      OP_J: begin
        d_alu = ALU_J; is_br = 1'b1; taken = 1'b1; d_target = j_target;
      end
      OP_JAL: begin
        d_alu = ALU_JAL; is_br = 1'b1; taken = 1'b1; d_target = j_target;
        d_wen = 1'b1; d_waddr = 5'd31; d_link = pc8;
      end
      default: d_alu = ALU_NOP;
    endcase
  end

  logic haz0, hazn, hazard, xfer;

  // Only ports the instruction actually reads can create a hazard.
  assign haz0   = in_valid && ((use1 && src0_1 && ld1) || (use2 && src0_2 && ld2));
  assign hazn   = in_valid && ((use1 && !src0_1 && ld1) || (use2 && !src0_2 && ld2));
  assign hazard = haz0 || hazn;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready) && !hazard;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_RUN: begin
        if (haz0) begin
          state_nx = S_STALL;
          cnt_nx   = CNT_W'(LOAD_LAT - 1);
        end
      end
      S_STALL: begin
        if (cnt != '0) cnt_nx = cnt - CNT_W'(1);
        else if (!hazard) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_alu          <= ALU_NOP;
      out_oprd1        <= '0;
      out_oprd2        <= '0;
      out_wen          <= 1'b0;
      out_waddr        <= 5'd0;
      out_link_addr    <= '0;
      out_in_delayslot <= 1'b0;
      jump_en          <= 1'b0;
      jump_target      <= '0;
      ds_flag          <= 1'b0;
    end else if (xfer) begin
      out_valid        <= 1'b1;
      out_alu          <= d_alu;
      out_oprd1        <= use1 ? val1 : sub1;
      out_oprd2        <= use2 ? val2 : sub2;
      out_wen          <= d_wen;
      out_waddr        <= d_waddr;
      out_link_addr    <= d_link;
      out_in_delayslot <= ds_flag;
      jump_en          <= taken;
      jump_target      <= d_target;
      ds_flag          <= is_br;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed self-checking bench for id_stage_fwd (LOAD_LAT=2, NUM_FWD=2).
module tb_id_stage_fwd;
  import id_stage_fwd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_addr = '0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [1:0]  fwd_en = '0;
  logic [9:0]  fwd_addr = '0;
  logic [63:0] fwd_data = '0;
  logic [1:0]  fwd_is_load = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  alu_t        out_alu;
  logic [31:0] out_oprd1, out_oprd2;
  logic        out_wen;
  logic [4:0]  out_waddr;
  logic [31:0] out_link_addr;
  logic        out_in_delayslot;
  logic        jump_en;
  logic [31:0] jump_target;

  logic [31:0] rf_mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  always #5 clk = ~clk;

  id_stage_fwd #(.DATA_W(32), .ADDR_W(32), .NUM_FWD(2), .LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_addr(in_addr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu),
    .out_oprd1(out_oprd1), .out_oprd2(out_oprd2), .out_wen(out_wen), .out_waddr(out_waddr),
    .out_link_addr(out_link_addr), .out_in_delayslot(out_in_delayslot),
    .jump_en(jump_en), .jump_target(jump_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the transfer with in_valid dropped.
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_addr  = addr;
    #1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("issue_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[0] = 32'hDEAD_BEEF;
    rf_mem[4] = 32'h0000_0044;
    rf_mem[5] = 32'h0000_1111;
    rf_mem[7] = 32'h0000_3000;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_jump_en", 32'(jump_en), 32'd0);
    check("rst_oprd1", out_oprd1, 32'd0);
    check("rst_ds", 32'(out_in_delayslot), 32'd0);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    // forward priority: OR r3,r5,r0
    fwd_en   = 2'b11;
    fwd_addr = {5'd5, 5'd5};
    fwd_data = {32'h0000_BBBB, 32'h0000_AAAA};
    in_inst  = 32'h00A0_1825;
    #1 check("raddr1", 32'(rf_raddr1), 32'd5);
    issue(32'h00A0_1825, 32'h0000_0000);
    check("fwd0_oprd1", out_oprd1, 32'h0000_AAAA);
    check("fwd0_oprd2_r0", out_oprd2, 32'd0);
    check("or_alu", 32'(out_alu), 32'(ALU_OR));
    check("or_waddr", 32'(out_waddr), 32'd3);
    fwd_en = 2'b10;
    issue(32'h00A0_1825, 32'h0000_0004);
    check("fwd1_oprd1", out_oprd1, 32'h0000_BBBB);
    fwd_en = 2'b00;
    issue(32'h00A0_1825, 32'h0000_0008);
    check("rf_oprd1", out_oprd1, 32'h0000_1111);

    // load-use on source 0: ADDIU r6,r4,1
    @(negedge clk);
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_data = {32'd0, 32'h0000_1234}; fwd_is_load = 2'b01;
    in_valid = 1'b1; in_inst = 32'h2486_0001; in_addr = 32'h0000_0010;
    #1 check("ld0_detect", 32'(in_ready), 32'd0);
    @(negedge clk);
    fwd_is_load = 2'b00; fwd_data = {32'd0, 32'h0000_0050};
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ld0_stall_cycles", 32'(n), 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("ld0_oprd1", out_oprd1, 32'h0000_0050);
    check("ld0_oprd2", out_oprd2, 32'h0000_0001);
    check("ld0_waddr", 32'(out_waddr), 32'd6);

    // load-use on source 1: hold without counter
    fwd_en = 2'b10; fwd_addr = {5'd4, 5'd0}; fwd_data = {32'h0000_0077, 32'd0}; fwd_is_load = 2'b10;
    in_valid = 1'b1; in_inst = 32'h2486_0001; in_addr = 32'h0000_0014;
    repeat (3) @(negedge clk);
    check("ld1_hold", 32'(in_ready), 32'd0);
    fwd_is_load = 2'b00;
    #1 check("ld1_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ld1_oprd1", out_oprd1, 32'h0000_0077);
    fwd_en = 2'b00;

    // backpressure: ORI r1,r0,0x00FF then XORI r2,r1,0x0F0F
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h3401_00FF, 32'h0000_0020);
    in_valid = 1'b1; in_inst = 32'h3822_0F0F; in_addr = 32'h0000_0024;
    for (int c = 0; c < 3; c++) begin
      check("bp_oprd2", out_oprd2, 32'h0000_00FF);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1 check("bp_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_oprd2", out_oprd2, 32'h0000_0F0F);
    check("bp_next_oprd1", out_oprd1, 32'h0000_1001);

    // branch and delay slots
    issue(32'h1000_0004, 32'h0000_0100);
    check("beq_jump_en", 32'(jump_en), 32'd1);
    check("beq_target", jump_target, 32'h0000_0114);
    check("beq_ds", 32'(out_in_delayslot), 32'd0);
    issue(32'h3401_00FF, 32'h0000_0104);
    check("slot_ds", 32'(out_in_delayslot), 32'd1);
    check("slot_jump_en", 32'(jump_en), 32'd0);
    issue(32'h3401_00FF, 32'h0000_0108);
    check("after_slot_ds", 32'(out_in_delayslot), 32'd0);
    issue(32'h1400_FFFF, 32'h0000_0200);
    check("bne_not_taken", 32'(jump_en), 32'd0);
    issue(32'h3401_00FF, 32'h0000_0204);
    check("bne_slot_ds", 32'(out_in_delayslot), 32'd1);

    // JAL, then JR in its delay slot
    issue(32'h0C00_0010, 32'h0040_0000);
    check("jal_waddr", 32'(out_waddr), 32'd31);
    check("jal_wen", 32'(out_wen), 32'd1);
    check("jal_link", out_link_addr, 32'h0040_0008);
    check("jal_target", jump_target, 32'h0000_0040);
    check("jal_jump_en", 32'(jump_en), 32'd1);
    issue(32'h00E0_0008, 32'h0040_0004);
    check("jr_target", jump_target, 32'h0000_3000);
    check("jr_ds", 32'(out_in_delayslot), 32'd1);
    check("jr_wen", 32'(out_wen), 32'd0);
    issue(32'h3401_00FF, 32'h0000_3000);
    check("jr_slot_ds", 32'(out_in_delayslot), 32'd1);

    // shift, LUI, unknown opcode, MOVN
    issue(32'h0007_4100, 32'h0000_3004);
    check("sll_oprd1", out_oprd1, 32'd4);
    check("sll_oprd2", out_oprd2, 32'h0000_3000);
    check("sll_ds", 32'(out_in_delayslot), 32'd0);
    issue(32'h3C09_1234, 32'h0000_3008);
    check("lui_oprd2", out_oprd2, 32'h1234_0000);
    issue(32'hFC00_0000, 32'h0000_300C);
    check("unk_valid", 32'(out_valid), 32'd1);
    check("unk_wen", 32'(out_wen), 32'd0);
    check("unk_alu", 32'(out_alu), 32'(ALU_NOP));
    issue(32'h00A7_500B, 32'h0000_3010);
`ifdef COND_MOVE_EN
    check("movn_wen", 32'(out_wen), 32'd1);
`else
    check("movn_wen", 32'(out_wen), 32'd0);
`endif

    // reset while stalled with a held bundle
    issue(32'h1000_0004, 32'h0000_0300);
    out_ready = 1'b0;
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd4}; fwd_is_load = 2'b01;
    in_valid = 1'b1; in_inst = 32'h2486_0001; in_addr = 32'h0000_0304;
    #1 check("rs_pre_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_jump_en", 32'(jump_en), 32'd0);
    in_valid = 1'b0; fwd_en = 2'b00; fwd_is_load = 2'b00; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rs_run", 32'(in_ready), 32'd1);
    issue(32'h2486_0001, 32'h0000_0400);
    check("rs_oprd1", out_oprd1, 32'h0000_0044);
    check("rs_oprd2", out_oprd2, 32'h0000_0001);
    check("rs_ds", 32'(out_in_delayslot), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
Registered, handshaked successor to the combinational decode stage. It decodes one instruction per transfer and resolves operands from the register file or from NUM_FWD forwarding sources with fixed priority. It detects load-use hazards and interlocks for LOAD_LAT cycles, tracks branch delay slots, and resolves branches and jumps in decode. It sits between the fetch/IF-ID register and the EX stage; its output register replaces the separate ID/EX register.

Parameters:
DATA_W, 32, operand/register data width
ADDR_W, 32, instruction address width
NUM_FWD, 2, forwarding sources; index 0 = youngest (EX), highest priority
LOAD_LAT, 1, interlock cycles inserted on a load-use hit against source 0 (1..7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction present
in_ready  out  1  stage accepts instruction this cycle
in_inst  in  32  instruction word
in_addr  in  ADDR_W  instruction address
rf_raddr1/rf_raddr2  out  5  register-file read addresses (rs/rt)
rf_rdata1/rf_rdata2  in  DATA_W  register-file read data, same cycle
fwd_en  in  NUM_FWD  per-source write enable
fwd_addr  in  5*NUM_FWD  per-source destination
fwd_data  in  DATA_W*NUM_FWD  per-source result
fwd_is_load  in  NUM_FWD  source holds a load whose data is not yet valid
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
out_alu  out  alu_t  ALU class/op from the decode table package
out_oprd1/out_oprd2  out  DATA_W  resolved operands (immediate/shamt substituted when the port is unused)
out_wen/out_waddr  out  1/5  destination write enable/address
out_link_addr  out  ADDR_W  in_addr+8 for JAL/JALR, else 0
out_in_delayslot  out  1  bundle is a delay-slot instruction
jump_en/jump_target  out  1/ADDR_W  redirect, valid only with out_valid

Behaviour:
- Reset: out_valid=0; all out_* fields, jump_en, jump_target and out_in_delayslot =0; FSM=RUN; delay-slot flag=0; stall counter=0.
- Latency: decoding is combinational on in_*; the bundle registers on transfer (in_valid&&in_ready) and appears the next cycle.
- Output handshake: out_* hold stable while out_valid&&!out_ready. in_ready = (state==RUN) && (!out_valid || out_ready) && !hazard.
- Operand resolution per read port: addr 0 -> 0. Otherwise the lowest-index i with fwd_en[i] && fwd_addr[i]==addr supplies fwd_data[i]. With no match, rf_rdata is used.
- Hazard: the matching source has fwd_is_load=1. Source 0 -> enter STALL with count=LOAD_LAT-1. Source i>0 -> hold in_ready low while the condition persists; no counter.
- FSM: RUN -> STALL on a source-0 load hazard while in_valid. STALL decrements each cycle. STALL -> RUN when count==0 and no hazard remains. In STALL, in_ready=0 and no bundle is produced. An existing bundle still drains via out_ready.
- Decoded set: AND/OR/XOR/NOR, SLL/SRL/SRA(+V), MFHI/MFLO/MTHI/MTLO, JR, JALR, ANDI/ORI/XORI (zero-ext), ADDIU (sign-ext), LUI ({imm,16'b0}), LW, BEQ/BNE/BGTZ/BLEZ, J, JAL. Unrecognised opcodes become a NOP bundle (out_wen=0, alu=0), still transferred.
- Branch target = in_addr+4+(sext(imm)<<2), modulo 2^ADDR_W. J/JAL target = {(in_addr+4)[31:28], idx, 2'b00}. JAL: waddr=31.
- Delay slot: any accepted branch/jump instruction sets the flag, whether taken or not. The next accepted instruction carries out_in_delayslot=1, and the flag clears on that transfer. A branch in a delay slot sets the flag again.
- Reset asserted mid-STALL or mid-hold returns all state to reset values immediately; the pending instruction is dropped.

Optional Feature:
COND_MOVE_EN
- Defined: MOVN/MOVZ decode. out_wen=1 only if the resolved rt is !=0 (MOVN) or ==0 (MOVZ); the forwarded value is used in the test.
- Undefined: MOVN/MOVZ decode as NOP bundles with out_wen=0.

Test Plan:
- Forward priority: fwd0 and fwd1 both write r5 (0xAAAA, 0xBBBB), rf=0x1111; issue OR r3,r5,r0 -> out_oprd1=0xAAAA; with fwd_en[0]=0 -> 0xBBBB.
- Load-use with LOAD_LAT=2: fwd0 load to r4 (is_load=1), issue ADDIU r6,r4,1 -> in_ready=0 for 2 cycles. Bundle appears after the stall with oprd1 taken from fwd data.
- Backpressure: out_ready=0 for 3 cycles after ORI r1,r0,0x00FF -> out_* stable (oprd2=0x000000FF), in_ready=0. Next instruction accepted on the cycle out_ready=1.
- Branch/delay slot: at addr 0x100, BEQ r0,r0,+4, then ORI -> jump_en=1, target=0x114. ORI bundle has out_in_delayslot=1; the following instruction has 0.
- JAL at 0x0040_0000 idx=0x10 -> waddr=31, out_link_addr=0x0040_0008, target=0x0000_0040.
- Reset mid-stall: assert rst during STALL -> out_valid=0 and state=RUN. After release, a fresh ADDIU decodes normally, with out_in_delayslot=0.
